// File: rtl/boot_byte_bridge.sv
// boot_byte_bridge: unpacks host boot words into bytes, buffers them in a
// byte FIFO, clips the stream at the captured ROM size and presents a
// valid/ready byte stream to the game loader. Single clock domain.
//
// Optional feature: define BOOT_SYNC_EN to enable the sync-byte hunt, which
// discards FIFO head bytes until SYNC_BYTE reaches the head.
//
// Ports:
//   clk, reset         sole clock, synchronous active-high reset
//   host_bootdata      boot word from the control module
//   host_bootdata_req  word available (four-phase request)
//   host_bootdata_ack  word consumed (four-phase acknowledge)
//   rom_size           image length in bytes, captured while reset is high
//   out_data/out_valid FIFO head byte and its valid flag
//   out_ready          sink accepts the head byte
//   bytes_loaded       bytes accepted into the FIFO since reset
//   level              bytes currently held
//   sync_found         sync byte has been popped (tied high without hunt)
//   done               whole image loaded and drained
module boot_byte_bridge #(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned DEPTH      = 16,
    parameter logic [7:0]  SYNC_BYTE  = 8'h4E,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [8*WORD_BYTES-1:0]       host_bootdata,
    input  logic                          host_bootdata_req,
    output logic                          host_bootdata_ack,
    input  logic [31:0]                   rom_size,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   bytes_loaded,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          sync_found,
    output logic                          done
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [31:0]     loaded_q, loaded_d;
    logic [31:0]     rom_size_q, rom_size_d;
    logic            sync_found_q, sync_found_d;

    logic [31:0]     remaining;
    logic [31:0]     keep;
    logic [31:0]     keep_wr;
    logic            room;
    logic            wr_en;
    logic [7:0]      head;
    logic            valid_c;
    logic            hunt_drop;
    logic            pop;

    // Bytes of this word that still fit inside the image, and FIFO room.
    always_comb begin
        remaining = (loaded_q < rom_size_q) ? (rom_size_q - loaded_q) : 32'd0;
        keep      = (remaining > 32'(WORD_BYTES)) ? 32'(WORD_BYTES) : remaining;
        // Words past the image end are always accepted so the host never stalls.
        room      = ((32'(DEPTH) - 32'(level_q)) >= 32'(WORD_BYTES)) ||
                    (loaded_q >= rom_size_q);
        head      = mem_q[rd_ptr_q];
    end

`ifdef BOOT_SYNC_EN
    // Non-sync head bytes are dropped internally until the sync byte is popped.
    always_comb begin
        hunt_drop    = !sync_found_q && (level_q != '0) && (head != SYNC_BYTE);
        valid_c      = (level_q != '0) && (sync_found_q || (head == SYNC_BYTE));
        pop          = (valid_c && out_ready) || hunt_drop;
        sync_found_d = sync_found_q || (pop && (head == SYNC_BYTE));
    end
`else
    logic unused_sync_byte;
    assign unused_sync_byte = ^SYNC_BYTE;

    always_comb begin
        hunt_drop    = 1'b0;
        valid_c      = (level_q != '0);
        pop          = valid_c && out_ready;
        sync_found_d = 1'b1;
    end
`endif

    // Handshake next state, word unpack and FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        loaded_d   = loaded_q;
        wr_en      = 1'b0;
        keep_wr    = 32'd0;
        rom_size_d = reset ? rom_size : rom_size_q;

        case (state_q)
            ST_IDLE: begin
                if (host_bootdata_req && room) begin
                    wr_en   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!host_bootdata_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_en) begin
            keep_wr = keep;
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                if (i < keep) begin
                    if (MSB_FIRST) begin
                        mem_d[wr_ptr_q + PW'(i)] = host_bootdata[8*(WORD_BYTES-1-i) +: 8];
                    end else begin
                        mem_d[wr_ptr_q + PW'(i)] = host_bootdata[8*i +: 8];
                    end
                end
            end
            wr_ptr_d = wr_ptr_q + PW'(keep);
            loaded_d = loaded_q + keep;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        level_d = level_q + LW'(keep_wr) - LW'(pop);
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        rom_size_q <= rom_size_d;
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            loaded_q     <= '0;
            sync_found_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            loaded_q     <= loaded_d;
            sync_found_q <= sync_found_d;
        end
    end

    // Byte storage; contents are don't-care once the pointers reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign host_bootdata_ack = (state_q == ST_ACK);
    assign out_data          = (level_q != '0) ? head : 8'h00;
    assign out_valid         = valid_c;
    assign bytes_loaded      = loaded_q;
    assign level             = level_q;
    assign sync_found        = sync_found_q;
    assign done              = (loaded_q >= rom_size_q) && (level_q == '0);

endmodule

// File: doc/boot_byte_bridge.md
# boot_byte_bridge

Parametrised bridge between the control module's word-wide boot-data handshake (`host_bootdata`/`req`/`ack`) and the byte-wide game loader. It unpacks each host word into bytes and buffers them in an internal byte FIFO. It enforces the ROM size limit, optionally hunts for the image sync byte, and presents a valid/ready byte stream. The whole block runs on a single clock, replacing the split-clock FIFO, gated loader clock and skip logic at the top level.

## Interface
Parameters:
- `WORD_BYTES`, 4: bytes per host word, 1..8.
- `DEPTH`, 16: FIFO depth in bytes; power of two, ≥ 2*`WORD_BYTES`.
- `SYNC_BYTE`, 8'h4E: first byte of a valid image.
- `MSB_FIRST`, 1: 1 = byte [8*WORD_BYTES-1 -: 8] emitted first; 0 = byte [7:0] first.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `host_bootdata`  in  8*WORD_BYTES  boot word from control module.
- `host_bootdata_req`  in  1  word available.
- `host_bootdata_ack`  out  1  word consumed.
- `rom_size`  in  32  image length in bytes; captured while `reset`=1.
- `out_data`  out  8  FIFO head byte.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  sink accepts byte.
- `bytes_loaded`  out  32  bytes accepted into FIFO since reset.
- `level`  out  $clog2(DEPTH)+1  bytes held.
- `sync_found`  out  1  sync byte seen.
- `done`  out  1  `bytes_loaded` ≥ captured size and `level`==0.

## Operation
- Reset values: `host_bootdata_ack`=0, `level`=0, `bytes_loaded`=0, `sync_found`=0, `out_valid`=0, `out_data`=0.
- `done`: 1 only if captured `rom_size`=0.
- `rom_size_q` loads `rom_size` every cycle `reset`=1 and holds afterwards.
- Handshake FSM, two states:
  - IDLE: if `req`=1 and (`DEPTH`-`level` ≥ `WORD_BYTES` or `bytes_loaded` ≥ `rom_size_q`), write word and go ACK.
  - ACK: `ack`=1; stay until `req`=0, then return to IDLE with `ack`=0.
  - Four-phase: `ack` is never high while `req` is low for more than one cycle.
- Word write:
  - keep = min(`WORD_BYTES`, `rom_size_q`-`bytes_loaded`).
  - First `keep` bytes in emission order go into the FIFO in one cycle; the remaining bytes are dropped.
  - `bytes_loaded` += keep.
  - keep=0: word acked and discarded.
- Sync hunt, active while `sync_found`=0:
  - Head ≠ `SYNC_BYTE`: popped internally, one per cycle; `out_valid`=0.
  - Head = `SYNC_BYTE`: `out_valid`=1 and the byte is presented; `sync_found` sets when it is popped.
- After sync: `out_valid` = (`level`≠0). Pop on `out_valid`&&`out_ready`.
- Level update: `level` += keep − pop, with write and pop allowed in the same cycle. The room check uses the pre-pop `level`.
- Pointers are $clog2(DEPTH) bits and wrap modulo `DEPTH`.

## Timing
- `ack` rises on the edge after `req`=1 is sampled with room. The word is written on that same edge.
- `ack` falls on the edge after `req`=0 is sampled.
- First-word fall-through: a byte written at edge N is on `out_data` with `out_valid`=1 after edge N. `out_data`/`out_valid` derive combinationally from head and `level`.
- Throughput limits:
  - Input: one word per 4-phase cycle (minimum 2 clocks).
  - Output: 1 byte/clock.
  - Hunt discard: 1 byte/clock.
- Reset mid-handshake: `ack` is 0 after the reset edge and FIFO contents are lost. The host must restart its request.
- FIFO full with `req`=1 (and not past `rom_size_q`): IDLE waits with `ack`=0 until a pop frees `WORD_BYTES` bytes.

## Configuration
- `BOOT_SYNC_EN` defined: sync hunt as above.
- `BOOT_SYNC_EN` undefined:
  - No hunt; every byte is presented.
  - `sync_found` is tied to 1 from the first cycle after reset.
  - `SYNC_BYTE` is unused.

## Test plan
- Order: `rom_size`=8, `MSB_FIRST`=1, words 0x4E45531A, 0x01020304, `out_ready`=1 → out 4E,45,53,1A,01,02,03,04; `bytes_loaded`=8; then `done`=1.
- Sync hunt (`BOOT_SYNC_EN`), `rom_size`=8: words 0x0000004E, 0x45531A00 → 00,00,00 dropped with `out_valid`=0; out 4E,45,53,1A,00; `sync_found`=1 after 4E popped.
- Partial word: `rom_size`=6, words 0x4E45531A, 0xAABBCCDD → out 4E,45,53,1A,AA,BB; `bytes_loaded`=6; CC/DD never appear.
- Backpressure (`DEPTH`=16, `out_ready`=0, synced): 4 words acked (`level`=16); 5th `req` gets no `ack`; after 4 pops the 5th word is acked within 1 cycle.
- Overrun: after `bytes_loaded`=`rom_size_q`, 3 extra words each acked; `level` and `bytes_loaded` unchanged.
- Reset during ACK: assert `reset` while `ack`=1 → next cycle `ack`=0, `level`=0, `bytes_loaded`=0, `out_valid`=0.
